// File: rtl/idu2exu_skid_if.sv
// idu2exu_skid_if: IDU->EXU handshake bundle; slave = stage (in_*/flush/out_ready in, in_ready/out_*/occupancy out), master = its environment
interface idu2exu_skid_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int SIDE_WIDTH = 70
);
  logic                  flush_i;
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [DATA_WIDTH-1:0] instr_i;
  logic [ADDR_WIDTH-1:0] instr_addr_i;
  logic [SIDE_WIDTH-1:0] side_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [DATA_WIDTH-1:0] instr_o;
  logic [ADDR_WIDTH-1:0] instr_addr_o;
  logic [SIDE_WIDTH-1:0] side_o;
  logic [1:0]            occupancy_o;
  modport slave (
    input  flush_i, in_valid_i, instr_i, instr_addr_i, side_i, out_ready_i,
    output in_ready_o, out_valid_o, instr_o, instr_addr_o, side_o, occupancy_o
  );
  modport master (
    output flush_i, in_valid_i, instr_i, instr_addr_i, side_i, out_ready_i,
    input  in_ready_o, out_valid_o, instr_o, instr_addr_o, side_o, occupancy_o
  );
endinterface

// File: rtl/idu2exu_skid.sv
// idu2exu_skid: 2-entry skid ID->EX register; ports clk, rst (sync, active-high) and bus (slave: valid/ready in/out, flush, occupancy)
module idu2exu_skid #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 12,
  parameter int                    SIDE_WIDTH = 70,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(32'h0000_0013)
) (
  input logic           clk,
  input logic           rst,
  idu2exu_skid_if.slave bus
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t                r_state, w_next;
  logic [DATA_WIDTH-1:0] r_m_instr, r_s_instr;
  logic [ADDR_WIDTH-1:0] r_m_addr, r_s_addr;
  logic [SIDE_WIDTH-1:0] r_m_side, r_s_side;
  logic                  w_in_fire, w_out_fire, w_load_m_in, w_load_m_s, w_load_s;
  assign bus.in_ready_o   = r_state != FULL;
  assign bus.out_valid_o  = r_state != EMPTY;
  assign bus.occupancy_o  = r_state;
  assign bus.instr_o      = bus.out_valid_o ? r_m_instr : NOP_INSTR;
  assign bus.instr_addr_o = bus.out_valid_o ? r_m_addr : '0;
  assign bus.side_o       = bus.out_valid_o ? r_m_side : '0;
  assign w_in_fire  = bus.in_valid_i & bus.in_ready_o;
  assign w_out_fire = bus.out_valid_o & bus.out_ready_i;
  always_comb begin
    w_next      = r_state;
    w_load_m_in = 1'b0;
    w_load_m_s  = 1'b0;
    w_load_s    = 1'b0;
    if (bus.flush_i) w_next = EMPTY;
    else
      case (r_state)
        EMPTY: if (w_in_fire) begin
          w_next      = ONE;
          w_load_m_in = 1'b1;
        end
        ONE: begin
          w_next      = w_in_fire ? (w_out_fire ? ONE : FULL) : (w_out_fire ? EMPTY : ONE);
          w_load_m_in = w_in_fire & w_out_fire;
          w_load_s    = w_in_fire & ~w_out_fire;
        end
        FULL: if (w_out_fire) begin
          w_next     = ONE;
          w_load_m_s = 1'b1;
        end
        default: w_next = EMPTY;
      endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= EMPTY;
      r_m_instr <= NOP_INSTR;
      r_m_addr  <= '0;
      r_m_side  <= '0;
      r_s_instr <= NOP_INSTR;
      r_s_addr  <= '0;
      r_s_side  <= '0;
    end else begin
      r_state <= w_next;
      if (w_load_m_in) begin
        r_m_instr <= bus.instr_i;
        r_m_addr  <= bus.instr_addr_i;
        r_m_side  <= bus.side_i;
      end else if (w_load_m_s) begin
        r_m_instr <= r_s_instr;
        r_m_addr  <= r_s_addr;
        r_m_side  <= r_s_side;
      end
      if (w_load_s) begin
        r_s_instr <= bus.instr_i;
        r_s_addr  <= bus.instr_addr_i;
        r_s_side  <= bus.side_i;
      end
    end
  end
endmodule
